// File: rtl/rggen_host_if_apb.sv
// rggen_host_if_apb: APB (v3) host interface for a register block.
// Turns one APB transfer into a single command to the register block and finishes the
// APB transfer when the block's one-cycle response strobe arrives.
// Optional feature macro: RGGEN_HOST_TIMEOUT_EN. It aborts a command that has seen no
// response within TIMEOUT_CYCLES cycles and reports it as a slave error.
module rggen_host_if_apb #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_psel,
    input  logic                     i_penable,
    input  logic                     i_pwrite,
    input  logic [ADDRESS_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0]    i_pwdata,
    output logic                     o_pready,
    output logic [DATA_WIDTH-1:0]    o_prdata,
    output logic                     o_pslverr,
    output logic                     o_command_valid,
    output logic                     o_read,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0]    o_write_data,
    input  logic                     i_response_ready,
    input  logic [DATA_WIDTH-1:0]    i_read_data,
    input  logic [1:0]               i_status
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMAND  = 2'd1,
        RESPONSE = 2'd2
    } state_e;

    state_e                   state_r;
    state_e                   state_next_s;
    logic                     setup_s;
    logic                     timeout_s;
    logic                     command_valid_r;
    logic                     pready_r;
    logic [DATA_WIDTH-1:0]    prdata_r;
    logic                     pslverr_r;
    logic                     read_r;
    logic [ADDRESS_WIDTH-1:0] address_r;
    logic [DATA_WIDTH-1:0]    write_data_r;
    logic                     command_valid_next_s;
    logic                     pready_next_s;
    logic [DATA_WIDTH-1:0]    prdata_next_s;
    logic                     pslverr_next_s;
    logic                     unused_exokay_s;

    // APB setup phase: select without enable
    assign setup_s = i_psel & ~i_penable;

    // The exokay status bit has no APB equivalent and is dropped
    assign unused_exokay_s = i_status[1];

`ifdef RGGEN_HOST_TIMEOUT_EN
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] count_r;

    // Count COMMAND cycles; held at zero outside COMMAND so every command starts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end else if (state_r == COMMAND) begin
            count_r <= count_r + COUNT_WIDTH'(1);
        end else begin
            count_r <= {COUNT_WIDTH{1'b0}};
        end
    end

    assign timeout_s = (state_r == COMMAND) && (count_r == COUNT_LAST);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a response strobe and a timeout both finish the command
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    state_next_s = COMMAND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COMMAND: begin
                if (i_response_ready || timeout_s) begin
                    state_next_s = RESPONSE;
                end else begin
                    state_next_s = COMMAND;
                end
            end
            RESPONSE: state_next_s = IDLE;
            default:  state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; the response strobe takes priority over timeout
    always_comb begin
        command_valid_next_s = (state_next_s == COMMAND);
        pready_next_s        = (state_next_s == RESPONSE);
        prdata_next_s        = {DATA_WIDTH{1'b0}};
        pslverr_next_s       = 1'b0;
        case (state_r)
            COMMAND: begin
                if (i_response_ready) begin
                    prdata_next_s  = read_r ? i_read_data : {DATA_WIDTH{1'b0}};
                    pslverr_next_s = i_status[0];
                end else if (timeout_s) begin
                    prdata_next_s  = {DATA_WIDTH{1'b0}};
                    pslverr_next_s = 1'b1;
                end else begin
                    prdata_next_s  = {DATA_WIDTH{1'b0}};
                    pslverr_next_s = 1'b0;
                end
            end
            default: begin
                prdata_next_s  = {DATA_WIDTH{1'b0}};
                pslverr_next_s = 1'b0;
            end
        endcase
    end

    // Output registers and command capture at the APB setup phase
    always_ff @(posedge clk) begin
        if (rst) begin
            command_valid_r <= 1'b0;
            pready_r        <= 1'b0;
            prdata_r        <= {DATA_WIDTH{1'b0}};
            pslverr_r       <= 1'b0;
            read_r          <= 1'b0;
            address_r       <= {ADDRESS_WIDTH{1'b0}};
            write_data_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            command_valid_r <= command_valid_next_s;
            pready_r        <= pready_next_s;
            prdata_r        <= prdata_next_s;
            pslverr_r       <= pslverr_next_s;
            if ((state_r == IDLE) && setup_s) begin
                read_r       <= ~i_pwrite;
                address_r    <= i_paddr;
                write_data_r <= i_pwrite ? i_pwdata : {DATA_WIDTH{1'b0}};
            end else begin
                read_r       <= read_r;
                address_r    <= address_r;
                write_data_r <= write_data_r;
            end
        end
    end

    assign o_command_valid = command_valid_r;
    assign o_read          = read_r;
    assign o_address       = address_r;
    assign o_write_data    = write_data_r;
    assign o_pready        = pready_r;
    assign o_prdata        = prdata_r;
    assign o_pslverr       = pslverr_r;

endmodule

// File: tb/tb_rggen_host_if_apb.sv
// Testbench for rggen_host_if_apb: directed vector table, hand-written reset/timeout
// sequences and randomized transfers checked against expectations derived from the
// transfer rules (cycle counts, data forwarding, error mapping).
module tb_rggen_host_if_apb;

`ifdef RGGEN_HOST_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
    localparam int LONG_NCMD  = 7;
`else
    localparam int TB_TIMEOUT = 8;
    localparam int LONG_NCMD  = 20;
`endif

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        command_valid;
    logic        read;
    logic [15:0] address;
    logic [31:0] write_data;
    logic        response_ready;
    logic [31:0] read_data;
    logic [1:0]  status;

    int n_cmp = 0;
    int n_err = 0;

    rggen_host_if_apb #(
        .ADDRESS_WIDTH  (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_psel           (psel),
        .i_penable        (penable),
        .i_pwrite         (pwrite),
        .i_paddr          (paddr),
        .i_pwdata         (pwdata),
        .o_pready         (pready),
        .o_prdata         (prdata),
        .o_pslverr        (pslverr),
        .o_command_valid  (command_valid),
        .o_read           (read),
        .o_address        (address),
        .o_write_data     (write_data),
        .i_response_ready (response_ready),
        .i_read_data      (read_data),
        .i_status         (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wd;
        int          ncmd;
        logic [31:0] rd;
        logic [1:0]  st;
        logic [31:0] exp_prdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input string what, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, what, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check(name, "pready", 64'(pready), 64'd0);
        check(name, "prdata", 64'(prdata), 64'd0);
        check(name, "pslverr", 64'(pslverr), 64'd0);
        check(name, "command_valid", 64'(command_valid), 64'd0);
    endtask

    // One APB transfer: setup, ncmd COMMAND cycles (strobe in the last one if strobe=1),
    // then the single pready cycle. Returns with the bench in the cycle after pready.
    task automatic xfer(input string name, input bit wr, input logic [15:0] addr,
                        input logic [31:0] wd, input int ncmd, input bit strobe,
                        input logic [31:0] rd, input logic [1:0] st,
                        input logic [31:0] exp_prdata, input bit exp_err, input bit violate);
        check_quiet({name, "@idle"});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        response_ready = 1'b0;
        step();
        for (int i = 0; i < ncmd; i++) begin
            check(name, "command_valid", 64'(command_valid), 64'd1);
            check(name, "read", 64'(read), 64'(!wr));
            check(name, "address", 64'(address), 64'(addr));
            check(name, "write_data", 64'(write_data), wr ? 64'(wd) : 64'd0);
            check(name, "pready_early", 64'(pready), 64'd0);
            psel = 1'b1; penable = 1'b1;
            if (violate) begin
                psel    = 1'($urandom);
                penable = 1'($urandom);
                pwrite  = 1'($urandom);
                paddr   = 16'($urandom);
                pwdata  = $urandom;
            end
            read_data = $urandom;
            status    = 2'($urandom);
            response_ready = strobe && (i == ncmd - 1);
            if (response_ready) begin
                read_data = rd;
                status    = st;
            end
            step();
        end
        response_ready = 1'b0;
        read_data = $urandom;
        check(name, "pready", 64'(pready), 64'd1);
        check(name, "prdata", 64'(prdata), 64'(exp_prdata));
        check(name, "pslverr", 64'(pslverr), 64'(exp_err));
        check(name, "command_valid_drop", 64'(command_valid), 64'd0);
        psel = 1'b1; penable = 1'b1;
        step();
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 16'h1234; pwdata = 32'h5555_AAAA;
        response_ready = 1'b1; read_data = 32'hFFFF_FFFF; status = 2'b11;

        vecs[0] = '{"wr_0010",     1'b1, 16'h0010, 32'h0000_1234, 2,         32'hA5A5_0000, 2'b00, 32'h0000_0000, 1'b0};
        vecs[1] = '{"rd_0004",     1'b0, 16'h0004, 32'hCAFE_0000, 2,         32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{"rd_unmapped", 1'b0, 16'h00FC, 32'h0000_0000, 2,         32'h0000_0000, 2'b01, 32'h0000_0000, 1'b1};
        vecs[3] = '{"rd_exokay",   1'b0, 16'h00FC, 32'h0000_0000, 2,         32'h0000_00AB, 2'b10, 32'h0000_00AB, 1'b0};
        vecs[4] = '{"wr_external", 1'b1, 16'h8000, 32'h0BAD_F00D, LONG_NCMD, 32'h1111_1111, 2'b00, 32'h0000_0000, 1'b0};
        vecs[5] = '{"wr_slverr",   1'b1, 16'h0020, 32'h0000_00FF, 3,         32'h2222_2222, 2'b11, 32'h0000_0000, 1'b1};
        vecs[6] = '{"rd_b2b",      1'b0, 16'hFFFC, 32'h0000_0000, 2,         32'h8000_0001, 2'b00, 32'h8000_0001, 1'b0};

        // Reset state, with a setup phase and a strobe present that reset must override
        repeat (3) step();
        check("reset", "pready", 64'(pready), 64'd0);
        check("reset", "prdata", 64'(prdata), 64'd0);
        check("reset", "pslverr", 64'(pslverr), 64'd0);
        check("reset", "command_valid", 64'(command_valid), 64'd0);
        check("reset", "read", 64'(read), 64'd0);
        check("reset", "address", 64'(address), 64'd0);
        check("reset", "write_data", 64'(write_data), 64'd0);
        rst = 1'b0; psel = 1'b0; response_ready = 1'b0;
        step();

        // Enable without a preceding setup, and a stray strobe, are ignored in IDLE
        psel = 1'b1; penable = 1'b1; response_ready = 1'b1;
        step();
        check_quiet("no_setup1");
        step();
        check_quiet("no_setup2");
        psel = 1'b0; penable = 1'b0; response_ready = 1'b0;
        step();

        // Directed vectors; the last pair runs back to back
        foreach (vecs[i]) begin
            xfer(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].ncmd, 1'b1,
                 vecs[i].rd, vecs[i].st, vecs[i].exp_prdata, vecs[i].exp_err, 1'b0);
        end
        xfer("b2b_second", 1'b1, 16'h0100, 32'h7654_3210, 2, 1'b1, 32'h0, 2'b00,
             32'h0, 1'b0, 1'b0);

        // Reset during the second COMMAND cycle of a write loses the transfer
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0040; pwdata = 32'h7777_0001;
        step();
        check("rst_mid", "cv_c1", 64'(command_valid), 64'd1);
        penable = 1'b1;
        step();
        check("rst_mid", "cv_c2", 64'(command_valid), 64'd1);
        rst = 1'b1;
        step();
        check_quiet("rst_mid");
        check("rst_mid", "read", 64'(read), 64'd0);
        check("rst_mid", "address", 64'(address), 64'd0);
        check("rst_mid", "write_data", 64'(write_data), 64'd0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        response_ready = 1'b1; read_data = 32'h1357_9BDF; status = 2'b01;
        step();
        check_quiet("late_strobe1");
        response_ready = 1'b0;
        step();
        check_quiet("late_strobe2");
        xfer("after_rst", 1'b0, 16'h0008, 32'h0, 2, 1'b1, 32'h0246_8ACE, 2'b00,
             32'h0246_8ACE, 1'b0, 1'b0);

`ifdef RGGEN_HOST_TIMEOUT_EN
        // No strobe: abort after TB_TIMEOUT COMMAND cycles with an error and no data
        xfer("timeout", 1'b0, 16'h0030, 32'h0, TB_TIMEOUT, 1'b0, 32'h0, 2'b00,
             32'h0, 1'b1, 1'b0);
        response_ready = 1'b1; read_data = 32'hFFFF_0000; status = 2'b00;
        step();
        check_quiet("timeout_late");
        response_ready = 1'b0;
        step();
        // Strobe in the last allowed cycle wins over the timeout
        xfer("timeout_edge", 1'b0, 16'h0034, 32'h0, TB_TIMEOUT, 1'b1, 32'h0000_5555, 2'b00,
             32'h0000_5555, 1'b0, 1'b0);
`endif

        // Randomized transfers with idle gaps, IDLE noise and master protocol violations
        for (int n = 0; n < 40; n++) begin
            bit          wr;
            bit          viol;
            logic [15:0] addr;
            logic [31:0] wd;
            logic [31:0] rd;
            logic [1:0]  st;
            int          ncmd;
            int          gap;
            wr   = 1'($urandom);
            viol = ($urandom_range(3, 0) == 0);
            addr = 16'($urandom);
            wd   = $urandom;
            rd   = $urandom;
            st   = 2'($urandom);
            ncmd = $urandom_range(6, 2);
            gap  = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) begin
                psel = 1'($urandom); penable = 1'b1;
                response_ready = 1'($urandom);
                step();
                check_quiet("rand_gap");
            end
            psel = 1'b0; penable = 1'b0; response_ready = 1'b0;
            xfer($sformatf("rand%0d", n), wr, addr, wd, ncmd, 1'b1, rd, st,
                 wr ? 32'h0 : rd, st[0], viol);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
